hazard1_shift_issue: RTL and testbench
======================================

// Module: hazard1_shift_issue
// PURPOSE
// Issue/result stage wrapped around the combinational barrel shifter. Accepts
// RV32I/Zbb shift ops (SLL/SRL/SRA/ROL/ROR, reg or imm shamt) over valid/ready.
// Decodes and registers the shifter controls (S1), then captures the shifter
// output into a result register (S2) for writeback. 2-stage pipeline, 1 op/cycle.
// PARAMETERS
// TAG_W       5  width of opaque tag (e.g. rd index) carried alongside each op
// ENABLE_ROT  1  1: ROL/ROR legal; 0: rotate encodings flagged illegal
// PORTS
// clk          in   1      clock
// rst          in   1      async reset, active-high
// flush        in   1      sync kill of all in-flight ops
// in_valid     in   1      request valid
// in_ready     out  1      request accepted when in_valid & in_ready at posedge
// in_funct3    in   3      instr[14:12]; 001 = left, 101 = right
// in_f7b30     in   1      instr[30]
// in_f7b29     in   1      instr[29] (Zbb rotate)
// in_rs1       in   32     data to shift
// in_shamt     in   5      shift amount (rs2[4:0] or imm[4:0], muxed upstream)
// in_tag       in   TAG_W  passthrough tag
// sh_din       out  32     to shifter: registered S1 rs1
// sh_shamt     out  5      to shifter: registered S1 shamt
// sh_right     out  1      to shifter: right_nleft
// sh_rotate    out  1      to shifter: rotate
// sh_arith     out  1      to shifter: arith
// sh_dout      in   32     from shifter: combinational result of sh_* inputs
// out_valid    out  1      result valid
// out_ready    in   1      consumer accepts when out_valid & out_ready at posedge
// out_result   out  32     shift result (0 when illegal)
// out_illegal  out  1      op was an illegal encoding
// out_tag      out  TAG_W  tag of the result
// BEHAVIOUR
// - Reset (async, rst=1): s1_valid=0, out_valid=0, all sh_*/out_* data regs 0.
//   Hence in_ready=1 on reset release.
// - Decode (at acceptance), f = {b30,b29}, funct3:
//   001 f=00 SLL; 101 f=00 SRL; 101 f=10 SRA; 001 f=11 ROL; 101 f=11 ROR.
//   Anything else illegal, incl. rotate when ENABLE_ROT=0. Illegal op: sh_*
//   controls all 0, sh_din=0, illegal flag carried; it still flows to out_*.
// - Control map: right = funct3[2]; arith = SRA; rotate = ROL|ROR.
// - S1 advance: s1_go = !out_valid | out_ready. in_ready = !s1_valid | s1_go.
// - S2 capture: on posedge, if s1_valid & s1_go: out_result <= illegal ? 0 :
//   sh_dout; out_tag/out_illegal from S1; out_valid <= 1.
//   Else if out_ready: out_valid <= 0.
// - S1 capture: if in_valid & in_ready, load S1 regs and set s1_valid;
//   else if s1_go, clear s1_valid.
// - Latency: op accepted at edge k -> out_valid=1 after edge k+1. Full
//   throughput under continuous out_ready; no bubble on back-to-back ops.
// - Backpressure: out_valid & !out_ready holds S2 and S1 stable (incl. sh_*),
//   in_ready=0 only if both stages full. No result dropped or duplicated.
// - shamt=0: result = rs1 for every legal op. SRA of negative by 31 -> 0xFFFFFFFF.
// - flush: at that edge s1_valid<=0 and out_valid<=0 regardless of handshakes;
//   an in_valid in the flush cycle is dropped (in_ready may read 1, but no op
//   is accepted). Data regs need not clear.
// - rst asserted mid-operation: all in-flight ops lost; no out_valid follows.
// - No combinational path in_* -> out_*; in_ready depends on state+out_ready only.
// TESTING
// - SLL rs1=0x0000_0001 shamt=31, out_ready=1 -> out_result 0x8000_0000,
//   out_valid after edge k+1.
// - SRA 0x8000_0000 sh=4 -> 0xF800_0000; SRL same -> 0x0800_0000;
//   ROR 0x0000_0001 sh=1 -> 0x8000_0000.
// - funct3=000, or ROL with ENABLE_ROT=0 -> out_illegal=1, out_result=0,
//   tag preserved.
// - 4 back-to-back ops, out_ready low 3 cycles mid-stream -> in_ready drops
//   after 2 accepted; all 4 delivered in order, exactly once.
// - flush with both stages full and in_valid=1 -> no out_valid next cycle;
//   next op accepted normally.
// - rst pulsed while out_valid=1 -> out_valid=0 immediately (async);
//   in_ready=1 after release.

Source files
------------

// File: rtl/hazard1_shift_issue.sv
// -----------------------------------------------------------------------------
// hazard1_shift_issue
//
// Issue/result stage wrapped around an external combinational barrel shifter.
// RV32I/Zbb shift ops (SLL/SRL/SRA/ROL/ROR) arrive over a valid/ready port,
// are decoded and registered into S1 (which drives the shifter controls), and
// the shifter output is captured into the S2 result register for writeback.
// Two stages, one op per cycle, full backpressure support.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   flush                synchronous kill of every in-flight op
//   in_valid/in_ready    request handshake
//   in_funct3            instr[14:12] (001 left, 101 right)
//   in_f7b30, in_f7b29   instr[30], instr[29] (arith / Zbb rotate select)
//   in_rs1, in_shamt     operand and shift amount
//   in_tag               opaque tag carried with the op
//   sh_din .. sh_arith   registered S1 controls to the shifter
//   sh_dout              combinational shifter result for the sh_* inputs
//   out_valid/out_ready  result handshake
//   out_result           shift result (0 for illegal encodings)
//   out_illegal          op was an illegal encoding
//   out_tag              tag of the result
// -----------------------------------------------------------------------------
module hazard1_shift_issue #(
  parameter int TAG_W      = 5,
  parameter bit ENABLE_ROT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_f7b30,
  input  logic             in_f7b29,
  input  logic [31:0]      in_rs1,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sh_din,
  output logic [4:0]       sh_shamt,
  output logic             sh_right,
  output logic             sh_rotate,
  output logic             sh_arith,
  input  logic [31:0]      sh_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ROL,
    OP_ROR,
    OP_ILL
  } op_e;

  // S1 payload: everything the shifter and S2 need for one op.
  typedef struct packed {
    logic [31:0]      din;
    logic [4:0]       shamt;
    logic             right;
    logic             rotate;
    logic             arith;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } s1_t;

  // S2 payload: the writeback result.
  typedef struct packed {
    logic [31:0]      result;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } s2_t;

  op_e  dec_op;
  s1_t  dec_s1;

  logic s1_valid_q, s1_valid_d;
  s1_t  s1_q, s1_d;
  logic out_valid_q, out_valid_d;
  s2_t  s2_q, s2_d;

  logic s1_go;
  logic accept;

  // ---------------------------------------------------------------------------
  // Decode. Rotates are only legal when the Zbb rotate support is enabled.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    dec_op = OP_ILL;
    case ({in_funct3, in_f7b30, in_f7b29})
      {3'b001, 2'b00}: dec_op = OP_SLL;
      {3'b101, 2'b00}: dec_op = OP_SRL;
      {3'b101, 2'b10}: dec_op = OP_SRA;
      {3'b001, 2'b11}: dec_op = ENABLE_ROT ? OP_ROL : OP_ILL;
      {3'b101, 2'b11}: dec_op = ENABLE_ROT ? OP_ROR : OP_ILL;
      default:         dec_op = OP_ILL;
    endcase
  end

  // Illegal ops present an all-zero control word to the shifter; only the
  // illegal flag and tag travel on.
  always_comb begin
    dec_s1         = '0;
    dec_s1.tag     = in_tag;
    dec_s1.illegal = (dec_op == OP_ILL);
    if (dec_op != OP_ILL) begin
      dec_s1.din    = in_rs1;
      dec_s1.shamt  = in_shamt;
      dec_s1.right  = in_funct3[2];
      dec_s1.rotate = (dec_op == OP_ROL) || (dec_op == OP_ROR);
      dec_s1.arith  = (dec_op == OP_SRA);
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control. S1 can move on whenever S2 is empty or draining, so
  // in_ready depends only on state and out_ready, never on in_*.
  // ---------------------------------------------------------------------------
  assign s1_go    = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_go;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    s2_d        = s2_q;

    // S2: capture the shifter output for the op currently held in S1.
    if (s1_valid_q && s1_go) begin
      out_valid_d    = 1'b1;
      s2_d.result    = s1_q.illegal ? 32'h0 : sh_dout;
      s2_d.illegal   = s1_q.illegal;
      s2_d.tag       = s1_q.tag;
    end else if (out_ready) begin
      out_valid_d    = 1'b0;
    end

    // S1: take a new op, or empty out once the held op has moved to S2.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = dec_s1;
    end else if (s1_go) begin
      s1_valid_d = 1'b0;
    end

    // Flush kills both stages; data registers keep whatever they hold.
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      s2_q        <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      s2_q        <= s2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs straight from registers.
  // ---------------------------------------------------------------------------
  assign sh_din      = s1_q.din;
  assign sh_shamt    = s1_q.shamt;
  assign sh_right    = s1_q.right;
  assign sh_rotate   = s1_q.rotate;
  assign sh_arith    = s1_q.arith;

  assign out_valid   = out_valid_q;
  assign out_result  = s2_q.result;
  assign out_illegal = s2_q.illegal;
  assign out_tag     = s2_q.tag;

endmodule

// File: tb/tb_hazard1_shift_issue.sv
// -----------------------------------------------------------------------------
// tb_hazard1_shift_issue
//
// Drives hazard1_shift_issue with directed and random shift ops. A behavioural
// shifter closes the sh_* / sh_dout loop. Expected results come from a
// reference model of the instruction semantics and are queued at acceptance;
// a monitor pops and compares whenever a result is handed over. A second
// instance with rotates disabled is checked on rotate encodings.
// -----------------------------------------------------------------------------
module tb_hazard1_shift_issue;

  localparam int TAG_W = 5;

  typedef struct packed {
    logic             illegal;
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic             in_f7b30;
  logic             in_f7b29;
  logic [31:0]      in_rs1;
  logic [4:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      sh_din;
  logic [4:0]       sh_shamt;
  logic             sh_right, sh_rotate, sh_arith;
  logic [31:0]      sh_dout;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  // Rotate-disabled instance
  logic             nr_in_ready;
  logic [31:0]      nr_sh_din;
  logic [4:0]       nr_sh_shamt;
  logic             nr_sh_right, nr_sh_rotate, nr_sh_arith;
  logic [31:0]      nr_sh_dout;
  logic             nr_out_valid;
  logic [31:0]      nr_out_result;
  logic             nr_out_illegal;
  logic [TAG_W-1:0] nr_out_tag;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Bit-by-bit barrel shifter standing in for the external datapath.
  function automatic logic [31:0] shifter_env(input logic [31:0] din, input logic [4:0] sh,
                                              input logic right, input logic rotate,
                                              input logic arith);
    logic [31:0] r;
    int src;
    for (int i = 0; i < 32; i++) begin
      src = right ? i + int'(sh) : i - int'(sh);
      if (rotate)         r[i] = din[(src + 32) % 32];
      else if (src < 0)   r[i] = 1'b0;
      else if (src > 31)  r[i] = arith ? din[31] : 1'b0;
      else                r[i] = din[src];
    end
    return r;
  endfunction

  assign sh_dout    = shifter_env(sh_din, sh_shamt, sh_right, sh_rotate, sh_arith);
  assign nr_sh_dout = shifter_env(nr_sh_din, nr_sh_shamt, nr_sh_right, nr_sh_rotate, nr_sh_arith);

  hazard1_shift_issue #(.TAG_W(TAG_W), .ENABLE_ROT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_f7b30(in_f7b30), .in_f7b29(in_f7b29),
    .in_rs1(in_rs1), .in_shamt(in_shamt), .in_tag(in_tag),
    .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_right(sh_right),
    .sh_rotate(sh_rotate), .sh_arith(sh_arith), .sh_dout(sh_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  hazard1_shift_issue #(.TAG_W(TAG_W), .ENABLE_ROT(1'b0)) u_dut_nr (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nr_in_ready),
    .in_funct3(in_funct3), .in_f7b30(in_f7b30), .in_f7b29(in_f7b29),
    .in_rs1(in_rs1), .in_shamt(in_shamt), .in_tag(in_tag),
    .sh_din(nr_sh_din), .sh_shamt(nr_sh_shamt), .sh_right(nr_sh_right),
    .sh_rotate(nr_sh_rotate), .sh_arith(nr_sh_arith), .sh_dout(nr_sh_dout),
    .out_valid(nr_out_valid), .out_ready(out_ready), .out_result(nr_out_result),
    .out_illegal(nr_out_illegal), .out_tag(nr_out_tag)
  );

  // Instruction-level reference: what the op means, not how it is built.
  function automatic exp_t ref_model(input logic [2:0] f3, input logic b30, input logic b29,
                                     input logic [31:0] rs1, input logic [4:0] sh,
                                     input logic [TAG_W-1:0] tag, input bit rot_en);
    exp_t        e;
    logic [63:0] dbl;
    dbl       = {rs1, rs1};
    e.tag     = tag;
    e.illegal = 1'b0;
    e.result  = 32'h0;
    if      (f3 == 3'b001 && {b30, b29} == 2'b00) e.result = rs1 << sh;
    else if (f3 == 3'b101 && {b30, b29} == 2'b00) e.result = rs1 >> sh;
    else if (f3 == 3'b101 && {b30, b29} == 2'b10) e.result = $unsigned($signed(rs1) >>> sh);
    else if (rot_en && f3 == 3'b001 && {b30, b29} == 2'b11) begin
      dbl      = dbl << sh;
      e.result = dbl[63:32];
    end else if (rot_en && f3 == 3'b101 && {b30, b29} == 2'b11) begin
      dbl      = dbl >> sh;
      e.result = dbl[31:0];
    end else e.illegal = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not happen as required", name);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: push at acceptance, pop and compare at every output handover.
  // Inputs only change shortly after posedge, so negedge sees the values the
  // next posedge will act on.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_event("sb_unexpected_output");
        else check("sb_result", 64'({out_illegal, out_result, out_tag}), 64'(exp_q.pop_front()));
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(ref_model(in_funct3, in_f7b30, in_f7b29, in_rs1, in_shamt, in_tag, 1'b1));
    end
  end

  always @(posedge rst) exp_q.delete();

  // Present one op and hold it until accepted (bounded).
  task automatic issue(input logic [2:0] f3, input logic b30, input logic b29,
                       input logic [31:0] rs1, input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    bit r;
    int n;
    in_valid = 1'b1; in_funct3 = f3; in_f7b30 = b30; in_f7b29 = b29;
    in_rs1 = rs1; in_shamt = sh; in_tag = tag;
    n = 0;
    do begin
      @(negedge clk);
      r = in_ready && !flush;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 200);
    if (!r) fail_event("issue_timeout");
    in_valid = 1'b0;
  endtask

  // Issue into an otherwise idle pipe with out_ready=1 and check latency/value.
  task automatic issue_check(input string name, input logic [2:0] f3, input logic b30,
                             input logic b29, input logic [31:0] rs1, input logic [4:0] sh,
                             input logic [TAG_W-1:0] tag, input logic [31:0] exp_res,
                             input logic exp_ill);
    issue(f3, b30, b29, rs1, sh, tag);
    check({name, "_early"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_data"}, 64'({out_illegal, out_result, out_tag}), 64'({exp_ill, exp_res, tag}));
  endtask

  bit rand_done;

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_f7b30 = 1'b0; in_f7b29 = 1'b0; in_rs1 = '0; in_shamt = '0; in_tag = '0;
    rand_done = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sh_din", 64'(sh_din), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed single ops
    issue_check("sll31", 3'b001, 1'b0, 1'b0, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000, 1'b0);
    issue_check("sra4",  3'b101, 1'b1, 1'b0, 32'h8000_0000, 5'd4,  5'd4, 32'hF800_0000, 1'b0);
    issue_check("srl4",  3'b101, 1'b0, 1'b0, 32'h8000_0000, 5'd4,  5'd5, 32'h0800_0000, 1'b0);
    issue_check("ror1",  3'b101, 1'b1, 1'b1, 32'h0000_0001, 5'd1,  5'd6, 32'h8000_0000, 1'b0);
    issue_check("f3_000", 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd7, 5'd9, 32'h0, 1'b1);
    issue_check("rol1",  3'b001, 1'b1, 1'b1, 32'h8000_0001, 5'd1,  5'd10, 32'h0000_0003, 1'b0);
    check("norot_rol_valid", 64'(nr_out_valid), 64'(1));
    check("norot_rol_data", 64'({nr_out_illegal, nr_out_result, nr_out_tag}),
          64'({1'b1, 32'h0, 5'd10}));
    issue_check("sra0",  3'b101, 1'b1, 1'b0, 32'h8000_0000, 5'd0,  5'd11, 32'h8000_0000, 1'b0);
    issue_check("sll0",  3'b001, 1'b0, 1'b0, 32'h1234_5678, 5'd0,  5'd12, 32'h1234_5678, 1'b0);
    issue_check("sra31", 3'b101, 1'b1, 1'b0, 32'h8000_0000, 5'd31, 5'd13, 32'hFFFF_FFFF, 1'b0);
    issue_check("sll_b30", 3'b001, 1'b1, 1'b0, 32'h0000_00FF, 5'd4, 5'd14, 32'h0, 1'b1);

    // Backpressure: 4 ops, consumer stalls while the stream is in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b0, 32'h0000_000A, 5'd1, 5'd1);
    issue(3'b101, 1'b0, 1'b0, 32'h0000_0B00, 5'd8, 5'd2);
    fork
      begin
        issue(3'b101, 1'b1, 1'b0, 32'hC000_0000, 5'd2, 5'd3);
        issue(3'b001, 1'b1, 1'b1, 32'h000D_0000, 5'd16, 5'd4);
      end
      begin
        for (int c = 0; c < 3; c++) begin
          check("bp_in_ready_low", 64'(in_ready), 64'(0));
          check("bp_sh_din_held", 64'(sh_din), 64'(32'h0000_0B00));
          check("bp_out_held", 64'({out_valid, out_result, out_tag}), 64'({1'b1, 32'h14, 5'd1}));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) fail_event("bp_drain");

    // Flush with both stages full and a request pending
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b0, 32'h1, 5'd1, 5'd20);
    issue(3'b001, 1'b0, 1'b0, 32'h2, 5'd1, 5'd21);
    in_valid = 1'b1; in_funct3 = 3'b001; in_f7b30 = 1'b0; in_f7b29 = 1'b0;
    in_rs1 = 32'h3; in_shamt = 5'd1; in_tag = 5'd22;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check("flush_no_late_out", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    issue_check("post_flush", 3'b101, 1'b0, 1'b0, 32'hF0F0_0000, 5'd4, 5'd23, 32'h0F0F_0000, 1'b0);

    // Async reset while a result is waiting
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b0, 32'h5, 5'd2, 5'd24);
    @(posedge clk); #1;
    check("prerst_out_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1 check("rst_async_out_valid", 64'(out_valid), 64'(0));
    #2 rst = 1'b0;
    out_ready = 1'b1;
    #1 check("rst_release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check("rst_no_late_out", 64'(out_valid), 64'(0));

    // Random traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [2:0] f3;
          case ($urandom_range(0, 5))
            0, 1:    f3 = 3'b001;
            2, 3:    f3 = 3'b101;
            4:       f3 = 3'b000;
            default: f3 = 3'($urandom);
          endcase
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          issue(f3, 1'($urandom), 1'($urandom), $urandom, 5'($urandom), TAG_W'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) fail_event("rand_drain");
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
